// File: rtl/uart_frame_tx_pkg.sv
// Shared definitions for the UART frame transmitter: state encoding,
// frame geometry and the byte-selection helper.
package uart_frame_tx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        DONE = ST_DONE
    } state_t;

    localparam logic [7:0] FRAME_HEADER  = 8'hA5;
    localparam int         PAYLOAD_BYTES = 4;
    localparam int         FRAME_LEN     = PAYLOAD_BYTES + 2;
    localparam int         IDX_W         = 3;

    // Index of the checksum byte, the final byte of a frame.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // Byte placed on the wire for a given position within the frame:
    // header, payload MSB first, then the running checksum.
    function automatic logic [7:0] frame_byte(
        input logic [8*PAYLOAD_BYTES-1:0] word,
        input logic [IDX_W-1:0]           idx,
        input logic [7:0]                 header,
        input logic [7:0]                 chk
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = header;
            3'd1:    b = word[31:24];
            3'd2:    b = word[23:16];
            3'd3:    b = word[15:8];
            3'd4:    b = word[7:0];
            default: b = chk;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_frame_tx.sv
// Serialises the packed {board_ID, points} word into a 6-byte frame
// (header, 4 payload bytes MSB first, XOR checksum) and writes it into
// the UART TX FIFO one byte per cycle, stalling while the FIFO is full.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter logic [7:0] HEADER     = FRAME_HEADER,
    parameter int         DATA_BYTES = PAYLOAD_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*DATA_BYTES-1:0] tx_data_stack,
    input  logic                    start,
    input  logic                    auto_en,
    input  logic                    tx_full,
    output logic                    wr_uart,
    output logic [7:0]              w_data,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int WORD_W = 8 * DATA_BYTES;

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         chk;
    logic [WORD_W-1:0]  word;
    logic [WORD_W-1:0]  last_sent;
    logic               trigger;
    logic               send_byte;
    logic               payload_byte;
    logic [7:0]         cur_byte;

    // Launch conditions and the byte currently addressed by idx.
    always_comb begin
        trigger      = (start | (auto_en & (tx_data_stack != last_sent)))
                       & (tx_data_stack != '0);
        send_byte    = (state == SEND) && !tx_full;
        payload_byte = (idx != '0) && (idx != LAST_IDX);
        cur_byte     = frame_byte(word, idx, HEADER, chk);
    end

    // Next-state logic: a frame ends once the checksum byte is accepted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trigger) state_nx = SEND;
            SEND:    if (send_byte && (idx == LAST_IDX)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Frame datapath and registered FIFO-side outputs; strobes default low.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_uart    <= 1'b0;
            w_data     <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            idx        <= '0;
            chk        <= 8'h00;
            word       <= '0;
            last_sent  <= '0;
        end else begin
            wr_uart    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        word <= tx_data_stack;
                        chk  <= 8'h00;
                        idx  <= '0;
                        busy <= 1'b1;
                    end
                end
                SEND: begin
                    if (send_byte) begin
                        wr_uart <= 1'b1;
                        w_data  <= cur_byte;
                        idx     <= idx + 3'd1;
                        if (payload_byte) chk <= chk ^ cur_byte;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    last_sent  <= word;
                    busy       <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with a byte-stream model of the frames
// the FIFO should receive and a per-cycle compare process.
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tx_data_stack;
    logic        start;
    logic        auto_en;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy;
    logic        frame_done;

    uart_frame_tx dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data_stack(tx_data_stack),
        .start        (start),
        .auto_en      (auto_en),
        .tx_full      (tx_full),
        .wr_uart      (wr_uart),
        .w_data       (w_data),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int byte_cnt = 0;
    int done_cnt = 0;
    bit en_cmp = 0;
    bit full_at_edge = 0;
    bit prev_last = 0;

    logic [7:0] exp_q[$];
    bit         last_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // XOR of the four payload bytes, computed from the word arithmetically.
    function automatic logic [7:0] model_chk(input logic [31:0] w);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4; i++) x ^= 8'((w >> (8 * i)) & 32'hFF);
        return x;
    endfunction

    // Append the expected frame for word w to the byte stream model.
    task automatic push_frame(input logic [31:0] w);
        exp_q.push_back(8'hA5); last_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
            last_q.push_back(1'b0);
        end
        exp_q.push_back(model_chk(w)); last_q.push_back(1'b1);
    endtask

    always @(posedge clk) full_at_edge = tx_full;

    // Per-cycle compare of the FIFO-side outputs against the byte stream model.
    always @(negedge clk) begin
        if (en_cmp) begin
            check("frame_done_timing", {31'b0, frame_done}, {31'b0, prev_last});
            prev_last = 1'b0;
            if (frame_done) done_cnt++;
            if (wr_uart) begin
                byte_cnt++;
                check("no_write_when_full", {31'b0, full_at_edge}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {24'b0, w_data}, 32'hFFFF_FFFF);
                end else begin
                    check("stream_byte", {24'b0, w_data}, {24'b0, exp_q.pop_front()});
                    prev_last = last_q.pop_front();
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (exp_q.size() == 0 && !busy && !wr_uart) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
        step();
        step();
    endtask

    task automatic wait_bytes(input int target, input string name);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (byte_cnt >= target) begin ok = 1; break; end
            step();
        end
        if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    int base_b;
    int base_d;

    initial begin
        rst = 1'b1; tx_data_stack = 32'h0; start = 1'b0; auto_en = 1'b0; tx_full = 1'b0;

        // Model pinned against hand-computed checksums.
        check("model_chk_0300_1234", {24'b0, model_chk(32'h0300_1234)}, 32'h25);
        check("model_chk_0100_0005", {24'b0, model_chk(32'h0100_0005)}, 32'h04);
        check("model_chk_0200_0001", {24'b0, model_chk(32'h0200_0001)}, 32'h03);

        // Reset state.
        step(); step(); step();
        check("rst_wr_uart", {31'b0, wr_uart}, 32'd0);
        check("rst_w_data", {24'b0, w_data}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        rst = 1'b0;
        en_cmp = 1'b1;
        step();

        // Basic frame with exact cycle timing.
        base_d = done_cnt;
        tx_data_stack = 32'h0300_1234;
        push_frame(32'h0300_1234);
        pulse_start();
        check("t1_busy_after_trigger", {31'b0, busy}, 32'd1);
        check("t1_no_write_yet", {31'b0, wr_uart}, 32'd0);
        step();
        check("t1_first_strobe", {31'b0, wr_uart}, 32'd1);
        check("t1_first_byte", {24'b0, w_data}, 32'hA5);
        for (int k = 1; k < 6; k++) begin
            step();
            check("t1_consecutive_strobe", {31'b0, wr_uart}, 32'd1);
            check("t1_busy_during", {31'b0, busy}, 32'd1);
        end
        check("t1_last_byte", {24'b0, w_data}, 32'h25);
        step();
        check("t1_frame_done", {31'b0, frame_done}, 32'd1);
        check("t1_busy_low", {31'b0, busy}, 32'd0);
        check("t1_wr_low", {31'b0, wr_uart}, 32'd0);
        wait_done("t1");
        check("t1_done_count", done_cnt - base_d, 32'd1);

        // Stall for three cycles after the second byte.
        base_b = byte_cnt; base_d = done_cnt;
        push_frame(32'h0300_1234);
        pulse_start();
        wait_bytes(base_b + 2, "t2_two_bytes");
        tx_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_stall_no_write", {31'b0, wr_uart}, 32'd0);
            check("t2_stall_busy", {31'b0, busy}, 32'd1);
        end
        tx_full = 1'b0;
        wait_done("t2");
        check("t2_bytes", byte_cnt - base_b, 32'd6);
        check("t2_done_count", done_cnt - base_d, 32'd1);

        // Zero word never triggers; then auto send with a simultaneous start.
        base_b = byte_cnt;
        tx_data_stack = 32'h0;
        pulse_start();
        for (int k = 0; k < 4; k++) step();
        check("t3_zero_busy", {31'b0, busy}, 32'd0);
        check("t3_zero_bytes", byte_cnt - base_b, 32'd0);
        auto_en = 1'b1;
        step(); step();
        check("t3_auto_zero_idle", {31'b0, busy}, 32'd0);
        base_d = done_cnt;
        tx_data_stack = 32'h0100_0005;
        push_frame(32'h0100_0005);
        pulse_start();
        wait_done("t3");
        for (int k = 0; k < 20; k++) step();
        check("t3_single_frame_bytes", byte_cnt - base_b, 32'd6);
        check("t3_done_count", done_cnt - base_d, 32'd1);
        check("t3_idle_after", {31'b0, busy}, 32'd0);

        // Word change and start during a frame, auto_en off: dropped.
        auto_en = 1'b0;
        base_b = byte_cnt; base_d = done_cnt;
        tx_data_stack = 32'h0300_1234;
        push_frame(32'h0300_1234);
        pulse_start();
        wait_bytes(base_b + 1, "t4a_first");
        tx_data_stack = 32'h0200_0001;
        pulse_start();
        wait_done("t4a");
        for (int k = 0; k < 20; k++) step();
        check("t4a_bytes", byte_cnt - base_b, 32'd6);
        check("t4a_done_count", done_cnt - base_d, 32'd1);

        // Same with auto_en on: the changed word follows as a second frame.
        auto_en = 1'b1;
        base_b = byte_cnt; base_d = done_cnt;
        tx_data_stack = 32'h0300_1234;
        push_frame(32'h0300_1234);
        push_frame(32'h0200_0001);
        pulse_start();
        wait_bytes(base_b + 1, "t4b_first");
        tx_data_stack = 32'h0200_0001;
        pulse_start();
        wait_done("t4b");
        for (int k = 0; k < 20; k++) step();
        check("t4b_bytes", byte_cnt - base_b, 32'd12);
        check("t4b_done_count", done_cnt - base_d, 32'd2);
        auto_en = 1'b0;

        // Reset after the third byte aborts the frame.
        base_b = byte_cnt; base_d = done_cnt;
        tx_data_stack = 32'h0300_1234;
        push_frame(32'h0300_1234);
        pulse_start();
        wait_bytes(base_b + 3, "t5_three");
        rst = 1'b1;
        exp_q.delete();
        last_q.delete();
        step();
        check("t5_rst_wr_uart", {31'b0, wr_uart}, 32'd0);
        check("t5_rst_w_data", {24'b0, w_data}, 32'd0);
        check("t5_rst_busy", {31'b0, busy}, 32'd0);
        check("t5_rst_frame_done", {31'b0, frame_done}, 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("t5_no_done_after_abort", done_cnt - base_d, 32'd0);
        check("t5_bytes_before_abort", byte_cnt - base_b, 32'd3);
        base_b = byte_cnt;
        push_frame(32'h0300_1234);
        pulse_start();
        wait_done("t5_resend");
        check("t5_resend_bytes", byte_cnt - base_b, 32'd6);
        check("t5_resend_done", done_cnt - base_d, 32'd1);
        check("t5_queue_empty", exp_q.size(), 32'd0);

        en_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
